// File: rtl/ladybird_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ladybird_bus_pkg
// Description : Shared types for the ladybird req/gnt/data_gnt bus secondary
//               endpoint. Holds the request and completion records, the
//               responder FSM encoding and a byte-strobe merge helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ladybird_bus_pkg;

   localparam int unsigned BUS_DATA_W = 32;
   localparam int unsigned BUS_STRB_W = BUS_DATA_W / 8;

   // One request as presented by the primary.
   typedef struct packed {
      logic                  req;
      logic [BUS_STRB_W-1:0] wstrb;
      logic [31:0]           addr;
      logic [BUS_DATA_W-1:0] data;
   } bus_request_s;

   // One entry of the completion pipeline.
   typedef struct packed {
      logic                  valid;
      logic                  is_read;
      logic [BUS_DATA_W-1:0] data;
   } bus_completion_s;

   // Responder FSM encoding.
   typedef enum logic [0:0] {
      RESP_READY = 1'b0,
      RESP_WAIT  = 1'b1
   } resp_state_e;

   // Replace the strobed byte lanes of old_word with those of new_word.
   function automatic logic [BUS_DATA_W-1:0] apply_wstrb(
      input logic [BUS_DATA_W-1:0] old_word,
      input logic [BUS_DATA_W-1:0] new_word,
      input logic [BUS_STRB_W-1:0] strb
   );
      logic [BUS_DATA_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < int'(BUS_STRB_W); i++) begin
         if (strb[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ladybird_bus_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ladybird_bus_sram_responder_if
// Description : Ladybird req/gnt/data_gnt bus bundle between one primary and
//               one secondary endpoint.
// Signals     : req, wstrb, addr, wdata   primary -> secondary
//               gnt, data_gnt, rdata,
//               rdata_oe                  secondary -> primary
// Modports    : master (primary side), slave (secondary side)
// Revision    : 1.0 - initial release
// ============================================================================
interface ladybird_bus_sram_responder_if;
   import ladybird_bus_pkg::*;

   logic                  req;
   logic [BUS_STRB_W-1:0] wstrb;
   logic [31:0]           addr;
   logic [BUS_DATA_W-1:0] wdata;
   logic                  gnt;
   logic                  data_gnt;
   logic [BUS_DATA_W-1:0] rdata;
   logic                  rdata_oe;

   modport master (
      output req, wstrb, addr, wdata,
      input  gnt, data_gnt, rdata, rdata_oe
   );

   modport slave (
      input  req, wstrb, addr, wdata,
      output gnt, data_gnt, rdata, rdata_oe
   );

endinterface
`default_nettype wire

// File: rtl/ladybird_bus_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ladybird_bus_resp_pipe
// Description : Fixed-depth shift register of bus completions. Every cycle a
//               new entry (possibly invalid) enters at stage 0 and the oldest
//               entry is presented at the head. Both resets flush all stages
//               so in-flight completions are dropped.
// Ports       : clk      clock
//               anrst    asynchronous active-low reset
//               nrst     synchronous active-low reset
//               i_push   entry entering stage 0 at the next edge
//               o_head   entry currently in the last stage
// Revision    : 1.0 - initial release
// ============================================================================
module ladybird_bus_resp_pipe
   import ladybird_bus_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk,
   input  logic            anrst,
   input  logic            nrst,
   input  bus_completion_s i_push,
   output bus_completion_s o_head
);

   bus_completion_s r_stage [DEPTH];

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_stage[i] <= '0;
         end
      end else if (!nrst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_push;
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_head = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ladybird_bus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ladybird_bus_sram_responder
// Description : Secondary endpoint of the ladybird bus backed by a
//               word-organised, byte-writable SRAM. Completes every accepted
//               transaction in order, exactly READ_LATENCY cycles after the
//               accept cycle, limits the number of outstanding transactions
//               and optionally inserts wait states after each grant.
// Ports       : clk            clock
//               anrst          asynchronous active-low reset
//               nrst           synchronous active-low reset (same effect)
//               bus (slave)    req/wstrb/addr/wdata in,
//                              gnt/data_gnt/rdata/rdata_oe out
// Revision    : 1.0 - initial release
// ============================================================================
module ladybird_bus_sram_responder
   import ladybird_bus_pkg::*;
#(
   parameter int unsigned ADDR_W          = 10,
   parameter int unsigned READ_LATENCY    = 2,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned WAIT_STATES     = 0
) (
   input  logic                          clk,
   input  logic                          anrst,
   input  logic                          nrst,
   ladybird_bus_sram_responder_if.slave  bus
);

   localparam int unsigned c_DEPTH = 1 << ADDR_W;
   localparam int unsigned c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [c_CNT_W-1:0] c_MAX_OUT   = c_CNT_W'(MAX_OUTSTANDING);
   localparam logic [3:0]         c_WAIT_LOAD = (WAIT_STATES > 0) ?
                                                4'(WAIT_STATES - 1) : 4'd0;

   localparam logic [0:0] c_ST_READY = RESP_READY;
   localparam logic [0:0] c_ST_WAIT  = RESP_WAIT;

   // ------------------------------------------------------------------------
   // Request capture
   // ------------------------------------------------------------------------
   bus_request_s          w_req;
   logic [ADDR_W-1:0]     w_idx;
   logic                  w_is_read;
   logic                  w_gnt;
   logic                  w_accept;
   logic                  w_unused;

   assign w_req = '{req:   bus.req,
                    wstrb: bus.wstrb,
                    addr:  bus.addr,
                    data:  bus.wdata};

   // Only the word-select bits matter; everything else aliases.
   assign w_idx     = w_req.addr[ADDR_W+1:2];
   assign w_is_read = (w_req.wstrb == '0);
   assign w_unused  = ^{w_req.addr[31:ADDR_W+2], w_req.addr[1:0]};

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]            r_state;
   logic [3:0]            r_wait_cnt;
   logic [c_CNT_W-1:0]    r_outstanding;
   // Held low through reset and for the first edge after it so gnt reads 0
   // while either reset is active.
   logic                  r_gnt_en;

   bus_completion_s       w_push;
   bus_completion_s       w_head;

   logic [BUS_DATA_W-1:0] r_mem [c_DEPTH];

   // A completion leaving the pipeline frees its slot in the same cycle, so
   // the limit is checked against the count after that departure. Everything
   // here is registered state; req never feeds back into gnt.
   assign w_gnt = r_gnt_en && (r_state == c_ST_READY) &&
                  ((r_outstanding < c_MAX_OUT) || w_head.valid);

   assign w_accept = w_req.req && w_gnt;

   // ------------------------------------------------------------------------
   // Memory: write on the accept edge, read captured into the pipeline on the
   // same edge. A read accepted after a write to the same word therefore
   // always sees the new data.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_accept && !w_is_read && nrst) begin
         r_mem[w_idx] <= apply_wstrb(r_mem[w_idx], w_req.data, w_req.wstrb);
      end
   end

   assign w_push = '{valid:   w_accept,
                     is_read: w_accept && w_is_read,
                     data:    (w_accept && w_is_read) ? r_mem[w_idx] : '0};

   ladybird_bus_resp_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_resp_pipe (
      .clk    (clk),
      .anrst  (anrst),
      .nrst   (nrst),
      .i_push (w_push),
      .o_head (w_head)
   );

   // ------------------------------------------------------------------------
   // Outstanding counter and grant FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         r_state       <= c_ST_READY;
         r_wait_cnt    <= '0;
         r_outstanding <= '0;
         r_gnt_en      <= 1'b0;
      end else if (!nrst) begin
         r_state       <= c_ST_READY;
         r_wait_cnt    <= '0;
         r_outstanding <= '0;
         r_gnt_en      <= 1'b0;
      end else begin
         r_gnt_en <= 1'b1;

         case ({w_accept, w_head.valid})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase

         case (r_state)
            c_ST_READY: begin
               if (w_accept && (WAIT_STATES > 0)) begin
                  r_state    <= c_ST_WAIT;
                  r_wait_cnt <= c_WAIT_LOAD;
               end
            end
            c_ST_WAIT: begin
               if (r_wait_cnt == 4'd0) begin
                  r_state <= c_ST_READY;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= c_ST_READY;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs from the pipeline head
   // ------------------------------------------------------------------------
   assign bus.gnt      = w_gnt;
   assign bus.data_gnt = w_head.valid;
   assign bus.rdata_oe = w_head.valid && w_head.is_read;
   assign bus.rdata    = (w_head.valid && w_head.is_read) ? w_head.data : '0;

   // A completion with nothing outstanding means the counter would wrap.
   a_no_underflow: assert property (
      @(posedge clk) disable iff (!anrst)
      w_head.valid |-> (r_outstanding != '0)
   );

endmodule
`default_nettype wire

// File: tb/tb_ladybird_bus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ladybird_bus_sram_responder
// Description : Self-checking bench. Three responders with different
//               latency / outstanding / wait-state settings share clk and
//               resets. Expected completions are queued when a request is
//               granted and compared when data_gnt arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ladybird_bus_sram_responder;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
      int          due;
   } exp_t;

   localparam int LAT [3] = '{2, 4, 2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        anrst;
   logic        nrst;
   logic        req_v   [3];
   logic [3:0]  wstrb_v [3];
   logic [31:0] addr_v  [3];
   logic [31:0] wdata_v [3];
   logic        gnt_v   [3];
   logic        dgnt_v  [3];
   logic        oe_v    [3];
   logic [31:0] rdata_v [3];

   exp_t        exp_q [3][$];
   int          acc_q [3][$];
   logic [31:0] mdl   [3][1024];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   exp_t mon_e;

   ladybird_bus_sram_responder_if bus_a ();
   ladybird_bus_sram_responder_if bus_b ();
   ladybird_bus_sram_responder_if bus_c ();

   assign bus_a.req   = req_v[0];
   assign bus_a.wstrb = wstrb_v[0];
   assign bus_a.addr  = addr_v[0];
   assign bus_a.wdata = wdata_v[0];
   assign gnt_v[0]    = bus_a.gnt;
   assign dgnt_v[0]   = bus_a.data_gnt;
   assign oe_v[0]     = bus_a.rdata_oe;
   assign rdata_v[0]  = bus_a.rdata;

   assign bus_b.req   = req_v[1];
   assign bus_b.wstrb = wstrb_v[1];
   assign bus_b.addr  = addr_v[1];
   assign bus_b.wdata = wdata_v[1];
   assign gnt_v[1]    = bus_b.gnt;
   assign dgnt_v[1]   = bus_b.data_gnt;
   assign oe_v[1]     = bus_b.rdata_oe;
   assign rdata_v[1]  = bus_b.rdata;

   assign bus_c.req   = req_v[2];
   assign bus_c.wstrb = wstrb_v[2];
   assign bus_c.addr  = addr_v[2];
   assign bus_c.wdata = wdata_v[2];
   assign gnt_v[2]    = bus_c.gnt;
   assign dgnt_v[2]   = bus_c.data_gnt;
   assign oe_v[2]     = bus_c.rdata_oe;
   assign rdata_v[2]  = bus_c.rdata;

   ladybird_bus_sram_responder #(
      .ADDR_W(10), .READ_LATENCY(2), .MAX_OUTSTANDING(2), .WAIT_STATES(0)
   ) u_dut_a (.clk(clk), .anrst(anrst), .nrst(nrst), .bus(bus_a));

   ladybird_bus_sram_responder #(
      .ADDR_W(10), .READ_LATENCY(4), .MAX_OUTSTANDING(2), .WAIT_STATES(0)
   ) u_dut_b (.clk(clk), .anrst(anrst), .nrst(nrst), .bus(bus_b));

   ladybird_bus_sram_responder #(
      .ADDR_W(10), .READ_LATENCY(2), .MAX_OUTSTANDING(2), .WAIT_STATES(3)
   ) u_dut_c (.clk(clk), .anrst(anrst), .nrst(nrst), .bus(bus_c));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Completion monitor / scoreboard.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (dgnt_v[d]) begin
            if (exp_q[d].size() == 0) begin
               chk("spurious_data_gnt", {31'b0, dgnt_v[d]}, 32'd0);
            end else begin
               mon_e = exp_q[d].pop_front();
               chk("data_gnt_cycle", cyc, mon_e.due);
               chk("rdata_oe", {31'b0, oe_v[d]}, {31'b0, mon_e.is_read});
               chk("rdata", rdata_v[d], mon_e.is_read ? mon_e.data : 32'h0);
            end
         end else begin
            chk("rdata_oe_idle", {31'b0, oe_v[d]}, 32'd0);
            chk("rdata_idle", rdata_v[d], 32'h0);
            if (exp_q[d].size() != 0 && exp_q[d][0].due < cyc) begin
               chk("data_gnt_missing", {31'b0, dgnt_v[d]}, 32'd1);
               void'(exp_q[d].pop_front());
            end
         end
      end
   end

   // Present a request, hold it until granted, queue its completion.
   // Returns #1 after the accept edge with req still asserted.
   task automatic drive(input int d, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] w);
      bit         ok;
      exp_t       e;
      logic [9:0] idx;
      ok         = 1'b0;
      req_v[d]   = 1'b1;
      wstrb_v[d] = s;
      addr_v[d]  = a;
      wdata_v[d] = w;
      idx        = a[11:2];
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if (gnt_v[d]) begin
            ok        = 1'b1;
            e.is_read = (s == 4'h0);
            e.data    = (s == 4'h0) ? mdl[d][idx] : 32'h0;
            e.due     = cyc + LAT[d];
            exp_q[d].push_back(e);
            acc_q[d].push_back(cyc);
            for (int b = 0; b < 4; b++) begin
               if (s[b]) mdl[d][idx][8*b +: 8] = w[8*b +: 8];
            end
         end
      end
      if (!ok) chk("gnt_timeout", {31'b0, gnt_v[d]}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int d);
      req_v[d] = 1'b0;
      for (int n = 0; n < 50 && exp_q[d].size() != 0; n++) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         req_v[d] = 1'b0; wstrb_v[d] = 4'h0; addr_v[d] = 32'h0; wdata_v[d] = 32'h0;
      end
      anrst = 1'b0;
      nrst  = 1'b0;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_gnt", {31'b0, gnt_v[d]}, 32'd0);
         chk("rst_data_gnt", {31'b0, dgnt_v[d]}, 32'd0);
      end
      @(posedge clk); #1;
      anrst = 1'b1;
      nrst  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk("gnt_after_rst", {31'b0, gnt_v[d]}, 32'd1);
      @(posedge clk); #1;

      // Single write then read, default settings.
      drive(0, 4'hF, 32'h10, 32'hDEADBEEF);
      drain(0);
      drive(0, 4'h0, 32'h10, 32'h0);
      drain(0);

      // Byte strobes, issued back to back: one accept per cycle.
      acc_q[0].delete();
      drive(0, 4'hF, 32'h20, 32'h11223344);
      drive(0, 4'h5, 32'h20, 32'hAABBCCDD);
      drive(0, 4'h0, 32'h20, 32'h0);
      drain(0);
      chk("b2b_accepts", acc_q[0].size(), 32'd3);
      if (acc_q[0].size() == 3) begin
         chk("b2b_gap1", acc_q[0][1] - acc_q[0][0], 32'd1);
         chk("b2b_gap2", acc_q[0][2] - acc_q[0][0], 32'd2);
      end

      // Aliasing plus read-after-write on the next cycle.
      drive(0, 4'hF, 32'h1000_0040, 32'hCAFEF00D);
      drive(0, 4'h0, 32'h0000_0040, 32'h0);
      drain(0);

      // Synchronous reset discards an in-flight read.
      drive(0, 4'h0, 32'h10, 32'h0);
      req_v[0] = 1'b0;
      nrst     = 1'b0;
      @(posedge clk); #1;
      exp_q[0].delete();
      nrst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      drive(0, 4'h0, 32'h10, 32'h0);
      drain(0);

      // Outstanding limit: latency 4, two outstanding, req held high.
      for (int i = 0; i < 4; i++) drive(1, 4'hF, 32'h100 + 32'(4*i), 32'hA5000000 + 32'(i*32'h111));
      drain(1);
      acc_q[1].delete();
      for (int i = 0; i < 4; i++) drive(1, 4'h0, 32'h100 + 32'(4*i), 32'h0);
      drain(1);
      chk("limit_accepts", acc_q[1].size(), 32'd4);
      if (acc_q[1].size() == 4) begin
         chk("limit_gap1", acc_q[1][1] - acc_q[1][0], 32'd1);
         chk("limit_gap2", acc_q[1][2] - acc_q[1][0], 32'd4);
         chk("limit_gap3", acc_q[1][3] - acc_q[1][0], 32'd5);
      end

      // Wait states: accepts exactly four cycles apart under continuous req.
      acc_q[2].delete();
      drive(2, 4'hF, 32'h80, 32'h01020304);
      drive(2, 4'h3, 32'h80, 32'hFFFF5566);
      drive(2, 4'hF, 32'h84, 32'h0BADCAFE);
      drive(2, 4'h0, 32'h80, 32'h0);
      drain(2);
      chk("ws_accepts", acc_q[2].size(), 32'd4);
      if (acc_q[2].size() == 4) begin
         for (int i = 1; i < 4; i++) chk("ws_gap", acc_q[2][i] - acc_q[2][i-1], 32'd4);
      end

      // Asynchronous reset while two reads are in flight.
      drive(1, 4'h0, 32'h100, 32'h0);
      drive(1, 4'h0, 32'h104, 32'h0);
      req_v[1] = 1'b0;
      anrst    = 1'b0;
      exp_q[1].delete();
      @(negedge clk);
      chk("midrst_gnt", {31'b0, gnt_v[1]}, 32'd0);
      chk("midrst_data_gnt", {31'b0, dgnt_v[1]}, 32'd0);
      @(posedge clk); #1;
      anrst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      drive(1, 4'h0, 32'h108, 32'h0);
      drain(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
